// File: rtl/btn_evt_pkg.sv
// Shared event codes, per-button FSM states and small elaboration helpers
// for the button event controller.
package btn_evt_pkg;

   typedef enum logic [1:0] {
      EVT_NONE   = 2'b00,
      EVT_SHORT  = 2'b01,
      EVT_LONG   = 2'b10,
      EVT_REPEAT = 2'b11
   } evt_code_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } btn_state_e;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Width that can hold 0..v-1, never narrower than one bit.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/btn_press_fsm.sv
// Per-button classifier: turns a debounced level into SHORT / LONG / REPEAT
// strobes, counted in ms ticks.
module btn_press_fsm
   import btn_evt_pkg::*;
#(
   parameter int LONG_MS   = 1000,
   parameter int REPEAT_MS = 200
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      lvl,
   input  logic      ms_tick,
   output logic      evt_stb,
   output evt_code_e evt_code
);

   localparam int CNT_W = clog2_min1(imax(LONG_MS, REPEAT_MS));
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS - 1);

   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;

   // Saturating increment; the terminal compares normally reset it first.
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Release is tested before the tick so a same-cycle release always wins.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      evt_stb  = 1'b0;
      evt_code = EVT_NONE;
      case (state_q)
         IDLE: begin
            if (lvl) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end
         end
         PRESSED: begin
            if (!lvl) begin
               evt_stb  = 1'b1;
               evt_code = EVT_SHORT;
               state_d  = IDLE;
               cnt_d    = '0;
            end else if (ms_tick) begin
               if (cnt_q == LONG_LAST) begin
                  evt_stb  = 1'b1;
                  evt_code = EVT_LONG;
                  state_d  = HELD;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         HELD: begin
            if (!lvl) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (ms_tick) begin
               if (cnt_q == REP_LAST) begin
                  evt_stb  = 1'b1;
                  evt_code = EVT_REPEAT;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/btn_event_ctrl.sv
// N-button press classifier with one-deep pending slots per button and a
// round-robin arbiter feeding a single registered valid/ready event port.
module btn_event_ctrl
   import btn_evt_pkg::*;
#(
   parameter int N_BTN     = 5,
   parameter int CLK_HZ    = 100_000_000,
   parameter int LONG_MS   = 1000,
   parameter int REPEAT_MS = 200,
   parameter int ID_W      = clog2_min1(N_BTN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] i_btn_lvl,
   output logic             o_evt_valid,
   input  logic             i_evt_ready,
   output logic [ID_W-1:0]  o_evt_id,
   output logic [1:0]       o_evt_code,
   output logic             o_ovf,
   input  logic             i_ovf_clr
);

   localparam int DIV   = CLK_HZ / 1000;
   localparam int DIV_W = clog2_min1(DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             ms_tick;

   logic [N_BTN-1:0]       evt_stb;
   logic [N_BTN-1:0][1:0]  evt_code;

   logic [N_BTN-1:0]       pend_vld_q, pend_vld_d;
   logic [N_BTN-1:0][1:0]  pend_code_q, pend_code_d;

   logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic                   evt_valid_q, evt_valid_d;
   logic [ID_W-1:0]        evt_id_q, evt_id_d;
   logic [1:0]             evt_code_q, evt_code_d;
   logic                   ovf_q, ovf_d;

   logic                   out_free;
   logic                   found;
   logic [ID_W-1:0]        win;
   logic [N_BTN-1:0]       grant;
   logic                   ovf_set;

   assign ms_tick = (div_q == DIV_LAST);

   always_comb begin
      div_d = ms_tick ? '0 : div_q + DIV_W'(1);
   end

   for (genvar g = 0; g < N_BTN; g++) begin : g_btn
      btn_press_fsm #(
         .LONG_MS   (LONG_MS),
         .REPEAT_MS (REPEAT_MS)
      ) u_fsm (
         .clk      (clk),
         .rst      (rst),
         .lvl      (i_btn_lvl[g]),
         .ms_tick  (ms_tick),
         .evt_stb  (evt_stb[g]),
         .evt_code (evt_code[g])
      );
   end

   // The output register may reload in the same cycle it is being accepted,
   // which is what gives one event per cycle under continuous ready.
   always_comb begin : arb
      logic [ID_W:0]   sum;
      logic [ID_W-1:0] idx;
      out_free = ~evt_valid_q | i_evt_ready;
      grant    = '0;
      found    = 1'b0;
      win      = '0;
      sum      = '0;
      idx      = '0;
      if (out_free) begin
         for (int k = 0; k < N_BTN; k++) begin
            sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_BTN)) sum = sum - (ID_W+1)'(N_BTN);
            idx = sum[ID_W-1:0];
            if (!found && pend_vld_q[idx]) begin
               found = 1'b1;
               win   = idx;
            end
         end
      end
      if (found) grant[win] = 1'b1;
   end

   // A granted slot is vacated this cycle, so a new strobe into it is not an overflow.
   always_comb begin
      pend_vld_d  = pend_vld_q & ~grant;
      pend_code_d = pend_code_q;
      ovf_set     = 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
         if (evt_stb[i]) begin
            pend_vld_d[i]  = 1'b1;
            pend_code_d[i] = evt_code[i];
            if (pend_vld_q[i] && !grant[i]) ovf_set = 1'b1;
         end
      end
   end

   always_comb begin
      evt_valid_d = evt_valid_q;
      evt_id_d    = evt_id_q;
      evt_code_d  = evt_code_q;
      rr_ptr_d    = rr_ptr_q;
      if (out_free) begin
         evt_valid_d = found;
         if (found) begin
            evt_id_d   = win;
            evt_code_d = pend_code_q[win];
            rr_ptr_d   = (win == ID_W'(N_BTN - 1)) ? '0 : win + ID_W'(1);
         end
      end
      ovf_d = ovf_set ? 1'b1 : (i_ovf_clr ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q       <= '0;
         pend_vld_q  <= '0;
         pend_code_q <= '0;
         rr_ptr_q    <= '0;
         evt_valid_q <= 1'b0;
         evt_id_q    <= '0;
         evt_code_q  <= '0;
         ovf_q       <= 1'b0;
      end else begin
         div_q       <= div_d;
         pend_vld_q  <= pend_vld_d;
         pend_code_q <= pend_code_d;
         rr_ptr_q    <= rr_ptr_d;
         evt_valid_q <= evt_valid_d;
         evt_id_q    <= evt_id_d;
         evt_code_q  <= evt_code_d;
         ovf_q       <= ovf_d;
      end
   end

   assign o_evt_valid = evt_valid_q;
   assign o_evt_id    = evt_id_q;
   assign o_evt_code  = evt_code_q;
   assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: directed scenarios plus random levels/ready,
// all compared against a tick-counting reference model.
module tb_btn_event_ctrl;

   localparam int N      = 3;
   localparam int CLK_HZ = 10_000;
   localparam int LONG   = 20;
   localparam int REP    = 5;
   localparam int DIV    = CLK_HZ / 1000;
   localparam int IDW    = 2;
   localparam logic [1:0] C_SHORT = 2'b01;
   localparam logic [1:0] C_LONG  = 2'b10;
   localparam logic [1:0] C_REP   = 2'b11;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   lvl = '0;
   logic           ready = 1'b1;
   logic           clr = 1'b0;
   logic           o_valid;
   logic [IDW-1:0] o_id;
   logic [1:0]     o_code;
   logic           o_ovf;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   btn_event_ctrl #(
      .N_BTN     (N),
      .CLK_HZ    (CLK_HZ),
      .LONG_MS   (LONG),
      .REPEAT_MS (REP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_btn_lvl   (lvl),
      .o_evt_valid (o_valid),
      .i_evt_ready (ready),
      .o_evt_id    (o_id),
      .o_evt_code  (o_code),
      .o_ovf       (o_ovf),
      .i_ovf_clr   (clr)
   );

   // Reference model: counts ms ticks since press as a plain integer and
   // classifies from that, then applies slot/arbiter rules per clock.
   int         m_div;
   bit         m_press [N];
   int         m_ticks [N];
   bit         m_sv [N];
   logic [1:0] m_sc [N];
   int         m_rr;
   logic       m_valid;
   logic [1:0] m_id;
   logic [1:0] m_code;
   logic       m_ovf;

   initial begin : model
      bit         tk, free, ovf_set;
      bit         ev [N];
      logic [1:0] evc [N];
      int         win, j;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_div = 0; m_rr = 0;
            m_valid = 0; m_id = 0; m_code = 0; m_ovf = 0;
            for (int i = 0; i < N; i++) begin
               m_press[i] = 0; m_ticks[i] = 0; m_sv[i] = 0; m_sc[i] = 0;
            end
         end else begin
            tk = (m_div == DIV - 1);
            m_div = tk ? 0 : m_div + 1;
            for (int i = 0; i < N; i++) begin
               ev[i] = 0; evc[i] = 0;
               if (!m_press[i]) begin
                  if (lvl[i]) begin m_press[i] = 1; m_ticks[i] = 0; end
               end else if (!lvl[i]) begin
                  m_press[i] = 0;
                  if (m_ticks[i] < LONG) begin ev[i] = 1; evc[i] = C_SHORT; end
               end else if (tk) begin
                  m_ticks[i]++;
                  if (m_ticks[i] == LONG) begin ev[i] = 1; evc[i] = C_LONG; end
                  else if (m_ticks[i] > LONG && (m_ticks[i] - LONG) % REP == 0) begin
                     ev[i] = 1; evc[i] = C_REP;
                  end
               end
            end
            free = !m_valid || ready;
            win = -1;
            if (free) begin
               for (int k = 0; k < N; k++) begin
                  j = (m_rr + k) % N;
                  if (win < 0 && m_sv[j]) win = j;
               end
               if (win >= 0) begin
                  m_valid = 1; m_id = 2'(win); m_code = m_sc[win];
                  m_sv[win] = 0; m_rr = (win + 1) % N;
               end else begin
                  m_valid = 0;
               end
            end
            ovf_set = 0;
            for (int i = 0; i < N; i++) begin
               if (ev[i]) begin
                  if (m_sv[i]) ovf_set = 1;
                  m_sv[i] = 1; m_sc[i] = evc[i];
               end
            end
            if (ovf_set) m_ovf = 1;
            else if (clr) m_ovf = 0;
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1; lvl = '0; ready = 1'b1; clr = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; lvl = 3'b111; ready = 1'b1; clr = 1'b1;
      @(negedge clk); #1;
      for (int c = 0; c < 3; c++) begin
         vectors++;
         if ({o_valid, o_id, o_code, o_ovf} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset cyc %0d: got v=%b id=%0d code=%0d ovf=%b, want all 0",
                     c, o_valid, o_id, o_code, o_ovf);
         end
         @(negedge clk); #1;
      end
      do_reset();
   endtask

   task automatic test_short();
      int nev = 0, first_c = -1;
      logic [1:0] ev_id = '1, ev_code = '0;
      do_reset();
      for (int c = 0; c < 70; c++) begin
         lvl = (c >= 5 && c < 55) ? 3'b001 : 3'b000;
         #1;
         vectors++;
         if (o_valid !== m_valid || o_ovf !== m_ovf || (m_valid && (o_id !== m_id || o_code !== m_code))) begin
            miscompares++;
            $display("FAIL short cyc %0d: got v=%b id=%0d code=%0d ovf=%b want v=%b id=%0d code=%0d ovf=%b",
                     c, o_valid, o_id, o_code, o_ovf, m_valid, m_id, m_code, m_ovf);
         end
         if (o_valid) begin
            nev++; ev_id = o_id; ev_code = o_code;
            if (first_c < 0) first_c = c;
         end
         @(negedge clk);
      end
      vectors++;
      if (nev !== 1) begin miscompares++; $display("FAIL short_count: got %0d want 1", nev); end
      vectors++;
      if (first_c !== 57) begin miscompares++; $display("FAIL short_latency: got cycle %0d want 57", first_c); end
      vectors++;
      if (ev_id !== 2'd0 || ev_code !== C_SHORT) begin
         miscompares++; $display("FAIL short_event: got id=%0d code=%0d want id=0 code=1", ev_id, ev_code);
      end
   endtask

   task automatic test_long_repeat();
      int nlong = 0, nrep = 0, nother = 0, long_c = -1, last_c = -1, bad_gap = 0;
      do_reset();
      for (int c = 0; c < 520; c++) begin
         lvl = (c < 470) ? 3'b010 : 3'b000;
         #1;
         vectors++;
         if (o_valid !== m_valid || o_ovf !== m_ovf || (m_valid && (o_id !== m_id || o_code !== m_code))) begin
            miscompares++;
            $display("FAIL long_repeat cyc %0d: got v=%b id=%0d code=%0d ovf=%b want v=%b id=%0d code=%0d ovf=%b",
                     c, o_valid, o_id, o_code, o_ovf, m_valid, m_id, m_code, m_ovf);
         end
         if (o_valid) begin
            if (o_id !== 2'd1) nother++;
            if (o_code === C_LONG) begin nlong++; long_c = c; last_c = c; end
            else if (o_code === C_REP) begin
               if (c - last_c != 50) bad_gap++;
               last_c = c; nrep++;
            end else nother++;
         end
         @(negedge clk);
      end
      vectors++;
      if (nlong !== 1 || long_c !== 201) begin
         miscompares++; $display("FAIL long_event: got %0d LONG at cycle %0d want 1 at 201", nlong, long_c);
      end
      vectors++;
      if (nrep !== 5) begin miscompares++; $display("FAIL repeat_count: got %0d want 5", nrep); end
      vectors++;
      if (bad_gap !== 0) begin miscompares++; $display("FAIL repeat_gap: got %0d bad gaps want 0", bad_gap); end
      vectors++;
      if (nother !== 0) begin miscompares++; $display("FAIL long_other: got %0d stray events want 0", nother); end
   endtask

   task automatic test_back_to_back();
      int got_c[$], got_id[$];
      int exp_c[4]  = '{33, 34, 73, 74};
      int exp_id[4] = '{0, 2, 0, 2};
      do_reset();
      for (int c = 0; c < 90; c++) begin
         lvl = ((c >= 2 && c < 31) || (c >= 40 && c < 71)) ? 3'b101 : 3'b000;
         #1;
         vectors++;
         if (o_valid !== m_valid || o_ovf !== m_ovf || (m_valid && (o_id !== m_id || o_code !== m_code))) begin
            miscompares++;
            $display("FAIL back_to_back cyc %0d: got v=%b id=%0d code=%0d ovf=%b want v=%b id=%0d code=%0d ovf=%b",
                     c, o_valid, o_id, o_code, o_ovf, m_valid, m_id, m_code, m_ovf);
         end
         if (o_valid) begin got_c.push_back(c); got_id.push_back(int'(o_id)); end
         @(negedge clk);
      end
      vectors++;
      if (got_c.size() != 4) begin
         miscompares++; $display("FAIL b2b_count: got %0d events want 4", got_c.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got_c[i] != exp_c[i] || got_id[i] != exp_id[i]) begin
               miscompares++;
               $display("FAIL b2b_event%0d: got id=%0d at %0d want id=%0d at %0d",
                        i, got_id[i], got_c[i], exp_id[i], exp_c[i]);
            end
         end
      end
      vectors++;
      if (o_ovf !== 1'b0) begin miscompares++; $display("FAIL b2b_ovf: got %b want 0", o_ovf); end
   endtask

   task automatic test_backpressure();
      int unstable = 0;
      logic [1:0] hs[$];
      do_reset();
      for (int c = 0; c < 300; c++) begin
         lvl   = ((c >= 2 && c < 11) || (c >= 20 && c < 29) || (c >= 40 && c < 255)) ? 3'b010 : 3'b000;
         ready = (c >= 270);
         clr   = (c == 280);
         #1;
         vectors++;
         if (o_valid !== m_valid || o_ovf !== m_ovf || (m_valid && (o_id !== m_id || o_code !== m_code))) begin
            miscompares++;
            $display("FAIL backpressure cyc %0d: got v=%b id=%0d code=%0d ovf=%b want v=%b id=%0d code=%0d ovf=%b",
                     c, o_valid, o_id, o_code, o_ovf, m_valid, m_id, m_code, m_ovf);
         end
         if (c >= 13 && c < 270 && (o_valid !== 1'b1 || o_id !== 2'd1 || o_code !== C_SHORT)) unstable++;
         if (c == 239 || c == 240 || c == 279 || c == 281) begin
            vectors++;
            if (o_ovf !== ((c == 240 || c == 279) ? 1'b1 : 1'b0)) begin
               miscompares++; $display("FAIL ovf_cyc%0d: got %b want %b", c, o_ovf, (c == 240 || c == 279));
            end
         end
         if (o_valid && ready) hs.push_back(o_code);
         @(negedge clk);
      end
      vectors++;
      if (unstable !== 0) begin miscompares++; $display("FAIL hold_stable: got %0d unstable cycles want 0", unstable); end
      vectors++;
      if (hs.size() != 2) begin
         miscompares++; $display("FAIL drain_count: got %0d want 2", hs.size());
      end else begin
         vectors++;
         if (hs[0] !== C_SHORT || hs[1] !== C_LONG) begin
            miscompares++; $display("FAIL drain_codes: got %0d,%0d want 1,2", hs[0], hs[1]);
         end
      end
   endtask

   task automatic test_release_on_tick();
      int nev = 0, ev_c = -1;
      logic [1:0] ev_code = '0, ev_id = '0;
      do_reset();
      for (int c = 0; c < 230; c++) begin
         lvl = (c < 199) ? 3'b100 : 3'b000;
         #1;
         vectors++;
         if (o_valid !== m_valid || o_ovf !== m_ovf || (m_valid && (o_id !== m_id || o_code !== m_code))) begin
            miscompares++;
            $display("FAIL release_on_tick cyc %0d: got v=%b id=%0d code=%0d ovf=%b want v=%b id=%0d code=%0d ovf=%b",
                     c, o_valid, o_id, o_code, o_ovf, m_valid, m_id, m_code, m_ovf);
         end
         if (o_valid) begin nev++; ev_c = c; ev_code = o_code; ev_id = o_id; end
         @(negedge clk);
      end
      vectors++;
      if (nev !== 1 || ev_c !== 201 || ev_code !== C_SHORT || ev_id !== 2'd2) begin
         miscompares++;
         $display("FAIL release_tick: got n=%0d cyc=%0d id=%0d code=%0d want n=1 cyc=201 id=2 code=1",
                  nev, ev_c, ev_id, ev_code);
      end
   endtask

   task automatic test_reset_in_held();
      int first_c = -1;
      logic [1:0] first_code = '0;
      do_reset();
      ready = 1'b0;
      for (int c = 0; c < 220; c++) begin
         lvl = 3'b010;
         #1;
         vectors++;
         if (o_valid !== m_valid || o_ovf !== m_ovf || (m_valid && (o_id !== m_id || o_code !== m_code))) begin
            miscompares++;
            $display("FAIL held_pre cyc %0d: got v=%b id=%0d code=%0d ovf=%b want v=%b id=%0d code=%0d ovf=%b",
                     c, o_valid, o_id, o_code, o_ovf, m_valid, m_id, m_code, m_ovf);
         end
         @(negedge clk);
      end
      vectors++;
      if (o_valid !== 1'b1 || o_code !== C_LONG) begin
         miscompares++; $display("FAIL held_setup: got v=%b code=%0d want v=1 code=2", o_valid, o_code);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if ({o_valid, o_id, o_code, o_ovf} !== 6'b0) begin
         miscompares++;
         $display("FAIL async_reset: got v=%b id=%0d code=%0d ovf=%b want all 0", o_valid, o_id, o_code, o_ovf);
      end
      @(negedge clk); @(negedge clk);
      ready = 1'b1;
      rst = 1'b0;
      for (int c = 0; c < 230; c++) begin
         #1;
         vectors++;
         if (o_valid !== m_valid || o_ovf !== m_ovf || (m_valid && (o_id !== m_id || o_code !== m_code))) begin
            miscompares++;
            $display("FAIL held_post cyc %0d: got v=%b id=%0d code=%0d ovf=%b want v=%b id=%0d code=%0d ovf=%b",
                     c, o_valid, o_id, o_code, o_ovf, m_valid, m_id, m_code, m_ovf);
         end
         if (o_valid && first_c < 0) begin first_c = c; first_code = o_code; end
         @(negedge clk);
      end
      vectors++;
      if (first_c !== 201 || first_code !== C_LONG) begin
         miscompares++;
         $display("FAIL relong: got cyc=%0d code=%0d want cyc=201 code=2", first_c, first_code);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 149) == 0) lvl[i] = ~lvl[i];
         if (c >= 2000 && c < 3000) ready = ($urandom_range(0, 7) == 0);
         else                       ready = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 49) == 0);
         #1;
         vectors++;
         if (o_valid !== m_valid || o_ovf !== m_ovf || (m_valid && (o_id !== m_id || o_code !== m_code))) begin
            miscompares++;
            $display("FAIL random cyc %0d: got v=%b id=%0d code=%0d ovf=%b want v=%b id=%0d code=%0d ovf=%b",
                     c, o_valid, o_id, o_code, o_ovf, m_valid, m_id, m_code, m_ovf);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_short();
      test_long_repeat();
      test_back_to_back();
      test_backpressure();
      test_release_on_tick();
      test_reset_in_held();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
